// File: rtl/cla_count_ctrl.sv
// Control stage for the carry-lookahead counter: holds the count, drives the external
// adder operands and applies up/down modulo, load, one-shot and terminal-count rules.
module cla_count_ctrl #(
   parameter int WIDTH     = 5,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             start,
   input  logic             stop,
   input  logic             up_dn,
   input  logic             oneshot,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy,
   output logic             done,
   output logic [1:0]       dbg_state
);

   localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic [WIDTH-1:0] clamp_val;
   logic [WIDTH-1:0] wrap_val;
   logic             tc_nxt;
   logic             at_term;

   // Up adds 0 with carry-in 1; down adds all ones (two's complement of 1).
   assign add_a   = count;
   assign add_b   = up_dn ? '0 : '1;
   assign add_cin = up_dn;

   assign clamp_val = (load_val > limit) ? limit : load_val;
   assign wrap_val  = up_dn ? '0 : limit;
   // add_cout can only be 1 when counting up from all ones, which is already >= limit.
   assign at_term   = up_dn ? ((count >= limit) || add_cout) : (count == '0);

   assign busy      = (state == RUN);
   assign done      = (state == DONE);
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= RST_COUNT;
         tc    <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         tc    <= tc_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      tc_nxt    = 1'b0;
      if (load) begin
         count_nxt = clamp_val;
      end else if (stop) begin
         if (state == RUN) state_nxt = IDLE;
      end else if (start && (state == IDLE)) begin
         state_nxt = RUN;
      end else if (start && (state == DONE)) begin
         state_nxt = RUN;
         count_nxt = wrap_val;
      end else if ((state == RUN) && en) begin
         if (!up_dn && (count > limit)) begin
            // limit was lowered below the count while counting down
            count_nxt = limit;
         end else if (at_term) begin
            tc_nxt = 1'b1;
            if (oneshot) state_nxt = DONE;
            else         count_nxt = wrap_val;
         end else begin
            count_nxt = add_sum;
         end
      end
   end

endmodule

// File: tb/tb_cla_count_ctrl.sv
// Directed bench for cla_count_ctrl with a behavioural 5-bit adder closing the loop.
module tb_cla_count_ctrl;

   logic       clk, rst_n;
   logic       en, start, stop, up_dn, oneshot, load;
   logic [4:0] load_val, limit;
   logic [4:0] add_a, add_b, add_sum, count;
   logic       add_cin, add_cout, tc, busy, done;
   logic [1:0] dbg_state;
   logic [5:0] adder_full;

   int checks = 0;
   int passed = 0;

   typedef struct {
      logic       ld, stp, st, en, up, os;
      logic [4:0] lv, lim;
      logic [4:0] cnt;
      logic       tc, bsy, dn;
   } vec_t;

   vec_t tbl[$];

   cla_count_ctrl #(.WIDTH(5), .RESET_VAL(0)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop),
      .up_dn(up_dn), .oneshot(oneshot), .load(load), .load_val(load_val),
      .limit(limit), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout), .count(count), .tc(tc),
      .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {5'b0, add_cin};
   assign add_sum    = adder_full[4:0];
   assign add_cout   = adder_full[5];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(input logic ld, stp, st, en_i, up, os,
                               input logic [4:0] lv, lim, cnt,
                               input logic tc_i, bsy, dn);
      vec_t v;
      v.ld = ld; v.stp = stp; v.st = st; v.en = en_i; v.up = up; v.os = os;
      v.lv = lv; v.lim = lim; v.cnt = cnt; v.tc = tc_i; v.bsy = bsy; v.dn = dn;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [4:0] act, exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
   endtask

   task automatic apply(input vec_t v, input int idx);
      load = v.ld; stop = v.stp; start = v.st; en = v.en; up_dn = v.up;
      oneshot = v.os; load_val = v.lv; limit = v.lim;
      @(posedge clk);
      #1;
      chk("count", idx, count, v.cnt);
      chk("tc", idx, {4'b0, tc}, {4'b0, v.tc});
      chk("busy", idx, {4'b0, busy}, {4'b0, v.bsy});
      chk("done", idx, {4'b0, done}, {4'b0, v.dn});
      chk("add_b", idx, add_b, v.up ? 5'h00 : 5'h1F);
      chk("add_cin", idx, {4'b0, add_cin}, {4'b0, v.up});
      if (v.up && (v.cnt == 5'd31)) begin
         chk("add_cout_at_31", idx, {4'b0, add_cout}, 5'd1);
         chk("add_sum_at_31", idx, add_sum, 5'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 0; start = 0; stop = 0; up_dn = 1; oneshot = 0;
      load = 0; load_val = 0; limit = 0;
      #12;
      chk("rst_count", 0, count, 5'd0);
      chk("rst_busy", 0, {4'b0, busy}, 5'd0);
      chk("rst_done", 0, {4'b0, done}, 5'd0);
      chk("rst_tc", 0, {4'b0, tc}, 5'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // up, limit 5
      tbl.push_back(mk(0,0,1,0,1,0, 0,5,  0,0,1,0));
      tbl.push_back(mk(0,0,0,1,1,0, 0,5,  1,0,1,0));
      tbl.push_back(mk(0,0,0,1,1,0, 0,5,  2,0,1,0));
      tbl.push_back(mk(0,0,0,1,1,0, 0,5,  3,0,1,0));
      tbl.push_back(mk(0,0,0,1,1,0, 0,5,  4,0,1,0));
      tbl.push_back(mk(0,0,0,1,1,0, 0,5,  5,0,1,0));
      tbl.push_back(mk(0,0,0,1,1,0, 0,5,  0,1,1,0));
      tbl.push_back(mk(0,0,0,1,1,0, 0,5,  1,0,1,0));
      tbl.push_back(mk(0,0,0,1,1,0, 0,5,  2,0,1,0));
      // down, limit 3, from 0
      tbl.push_back(mk(1,0,0,0,0,0, 0,3,  0,0,1,0));
      tbl.push_back(mk(0,0,0,1,0,0, 0,3,  3,1,1,0));
      tbl.push_back(mk(0,0,0,1,0,0, 0,3,  2,0,1,0));
      tbl.push_back(mk(0,0,0,1,0,0, 0,3,  1,0,1,0));
      tbl.push_back(mk(0,0,0,1,0,0, 0,3,  0,0,1,0));
      tbl.push_back(mk(0,0,0,1,0,0, 0,3,  3,1,1,0));
      // oneshot up, limit 2
      tbl.push_back(mk(1,0,0,0,1,0, 0,2,  0,0,1,0));
      tbl.push_back(mk(0,0,0,1,1,1, 0,2,  1,0,1,0));
      tbl.push_back(mk(0,0,0,1,1,1, 0,2,  2,0,1,0));
      tbl.push_back(mk(0,0,0,1,1,1, 0,2,  2,1,0,1));
      tbl.push_back(mk(0,0,0,1,1,1, 0,2,  2,0,0,1));
      tbl.push_back(mk(0,0,1,1,1,1, 0,2,  0,0,1,0));
      // load beats stop/start, clamps to limit
      tbl.push_back(mk(1,1,1,1,1,0, 9,7,  7,0,1,0));
      tbl.push_back(mk(0,1,0,1,1,0, 0,7,  7,0,0,0));
      tbl.push_back(mk(0,0,0,1,1,0, 0,7,  7,0,0,0));
      tbl.push_back(mk(0,0,1,1,1,0, 0,7,  7,0,1,0));
      tbl.push_back(mk(0,0,0,1,1,0, 0,7,  0,1,1,0));
      // limit 31 wrap through all ones
      tbl.push_back(mk(1,0,0,0,1,0, 30,31, 30,0,1,0));
      tbl.push_back(mk(0,0,0,1,1,0, 0,31,  31,0,1,0));
      tbl.push_back(mk(0,0,0,1,1,0, 0,31,  0,1,1,0));
      // limit 0: tc every enabled cycle
      tbl.push_back(mk(0,0,0,1,1,0, 0,0,  0,1,1,0));
      tbl.push_back(mk(0,0,0,1,1,0, 0,0,  0,1,1,0));
      tbl.push_back(mk(0,0,0,0,1,0, 0,0,  0,0,1,0));
      // down with limit lowered below count
      tbl.push_back(mk(1,0,0,0,0,0, 20,31, 20,0,1,0));
      tbl.push_back(mk(0,0,0,1,0,0, 0,10,  10,0,1,0));
      tbl.push_back(mk(0,0,0,1,0,0, 0,10,  9,0,1,0));
      tbl.push_back(mk(0,0,0,0,0,0, 0,10,  9,0,1,0));
      // leave tc high with a nonzero count before the reset test
      tbl.push_back(mk(1,0,0,0,0,0, 0,4,  0,0,1,0));
      tbl.push_back(mk(0,0,0,1,0,0, 0,4,  4,1,1,0));

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i + 1);

      // asynchronous reset between edges
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_count", 100, count, 5'd0);
      chk("midrst_busy", 100, {4'b0, busy}, 5'd0);
      chk("midrst_tc", 100, {4'b0, tc}, 5'd0);
      chk("midrst_done", 100, {4'b0, done}, 5'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      apply(mk(0,0,0,1,1,0, 0,5, 0,0,0,0), 101);
      apply(mk(0,0,1,0,1,0, 0,5, 0,0,1,0), 102);
      apply(mk(0,0,0,0,1,0, 0,5, 0,0,1,0), 103);
      apply(mk(0,0,0,1,1,0, 0,5, 1,0,1,0), 104);
      apply(mk(0,0,0,0,1,0, 0,5, 1,0,1,0), 105);
      apply(mk(0,0,0,1,1,0, 0,5, 2,0,1,0), 106);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
